// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared constants and state encoding for the MEM-stage access controller
package mips_pipe_pkg;

  localparam int DATA_W_DEF = 32;

  // Byte-offset bits that must be zero for a word access
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - clear/increment wait counter flagging the last allowed wait cycle
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// rtl/mem_stage_access_ctrl.sv - MEM-stage load/store sequencer with pipeline stall,
// alignment check and memory-wait timeout.
module mem_stage_access_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              pipe_enable,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              wb_valid,
  output logic              align_err,
  output logic              timeout_err
);

  mem_state_e r_state;
  mem_state_e w_next_state;
  logic       r_is_load;
  logic       w_mem_op;
  logic       w_misaligned;
  logic       w_clr;
  logic       w_inc;
  logic       w_last;

  assign w_mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
  assign w_misaligned = |(ex_addr[1:0] & WORD_ALIGN_MASK);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_last (w_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Stall everything upstream from the issuing cycle until DONE lets EX/MEM advance
  always_comb begin
    w_next_state = r_state;
    pipe_enable  = 1'b0;
    w_clr        = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_mem_op || w_misaligned) begin
          pipe_enable = 1'b1;
        end else begin
          w_clr        = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ready || w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_DONE: begin
        pipe_enable  = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_rdata    <= '0;
      wb_valid    <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      r_is_load   <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op && w_misaligned) begin
            align_err <= 1'b1;
            if (!ex_mem_write) begin
              wb_valid <= 1'b1;
              wb_rdata <= '0;
            end
          end else if (w_mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= ex_mem_write;
            mem_addr  <= {ex_addr[DATA_W-1:2], 2'b00};
            mem_wdata <= ex_wdata;
            r_is_load <= ~ex_mem_write;
          end
        end
        ST_ACCESS: begin
          // wb_valid is registered here so that it is high during DONE
          if (mem_ready) begin
            mem_req  <= 1'b0;
            wb_valid <= r_is_load;
            if (r_is_load) begin
              wb_rdata <= mem_rdata;
            end
          end else if (w_last) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            wb_valid    <= r_is_load;
            wb_rdata    <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// tb/tb_mem_stage_access_ctrl.sv - self-checking bench with a transaction-level timing model
module tb_mem_stage_access_ctrl;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [31:0] ex_addr, ex_wdata;
  logic        pipe_enable, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_rdata;
  logic        wb_valid, align_err, timeout_err;

  always #5 clock = ~clock;

  mem_stage_access_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .pipe_enable  (pipe_enable),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .wb_rdata     (wb_rdata),
    .wb_valid     (wb_valid),
    .align_err    (align_err),
    .timeout_err  (timeout_err)
  );

  logic        e_pe, e_req, e_we, e_wbv, e_align, e_terr;
  logic [31:0] e_addr, e_wdata, e_rdata;
  bit          chk_en = 0;
  bit          pend_align = 0;
  bit          pend_wbv = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          c_req = 0, c_pelow = 0, c_wbv = 0, c_align = 0, c_terr = 0;
  logic [31:0] wb_last = '0, wb_prev = '0, req_addr = '0;
  logic        req_we = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk1("pipe_enable", pipe_enable, e_pe);
      chk1("mem_req", mem_req, e_req);
      chk1("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("wb_rdata", wb_rdata, e_rdata);
      chk1("wb_valid", wb_valid, e_wbv);
      chk1("align_err", align_err, e_align);
      chk1("timeout_err", timeout_err, e_terr);
      if (mem_req) begin
        c_req++;
        req_addr = mem_addr;
        req_we   = mem_we;
      end
      if (!pipe_enable) c_pelow++;
      if (wb_valid) begin
        c_wbv++;
        wb_prev = wb_last;
        wb_last = wb_rdata;
      end
      if (align_err) c_align++;
      if (timeout_err) c_terr++;
    end
  end

  task automatic begin_cycle();
    @(posedge clock);
    #1;
    e_wbv   = pend_wbv;
    e_align = pend_align;
    e_terr  = 1'b0;
    if (pend_wbv) e_rdata = '0;
    pend_wbv   = 0;
    pend_align = 0;
    mem_ready  = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
  endtask

  // One instruction held in EX/MEM until it retires; lat = wait cycles before mem_ready
  task automatic do_op(input logic v, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input logic [31:0] rdat, input int rst_at);
    logic op, ld;
    int   last;
    op = v & (rd | wr);
    ld = op & ~wr;
    begin_cycle();
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_addr = a; ex_wdata = wd;
    e_req = 1'b0;
    if (!op || a[1:0] != 2'b00) begin
      e_pe       = 1'b1;
      pend_align = op;
      pend_wbv   = ld;
      return;
    end
    e_pe = 1'b0;
    last = (lat >= TO) ? TO - 1 : lat;
    for (int j = 0; j <= last; j++) begin
      begin_cycle();
      e_req = 1'b1; e_we = wr; e_addr = {a[31:2], 2'b00}; e_wdata = wd; e_pe = 1'b0;
      mem_ready = (j == lat);
      mem_rdata = (j == lat) ? rdat : $urandom;
      if (j == rst_at) begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        begin_cycle();
        reset = 1'b0;
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_addr = '0; ex_wdata = '0;
        e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_pe = 1'b1;
        return;
      end
    end
    begin_cycle();
    e_req  = 1'b0;
    e_pe   = 1'b1;
    e_wbv  = ld;
    e_terr = (lat >= TO);
    if (lat >= TO) e_rdata = '0;
    else if (ld) e_rdata = rdat;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_op(0, 0, 0, '0, '0, 0, '0, -1);
  endtask

  int          s_req, s_pe, s_wbv, s_align, s_terr;
  logic [31:0] ra, rw;
  int          rl, pick;
  logic        rv, rr, rwr;

  task automatic snap();
    s_req = c_req; s_pe = c_pelow; s_wbv = c_wbv; s_align = c_align; s_terr = c_terr;
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_addr = '0; ex_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    e_pe = 1'b1; e_req = 0; e_we = 0; e_wbv = 0; e_align = 0; e_terr = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_en = 1;
    reset  = 1'b0;
    idle(1);

    snap();
    do_op(1, 1, 0, 32'h0000_0010, '0, 0, 32'hDEAD_BEEF, -1);
    idle(2);
    chk("load_req_cycles", c_req - s_req, 1);
    chk("load_stall_cycles", c_pelow - s_pe, 2);
    chk("load_wbv_pulses", c_wbv - s_wbv, 1);
    chk("load_rdata", wb_last, 32'hDEAD_BEEF);
    chk("load_addr", req_addr, 32'h0000_0010);
    chk1("load_we", req_we, 1'b0);

    snap();
    do_op(1, 0, 1, 32'h0000_0020, 32'h1234_5678, 3, '0, -1);
    idle(2);
    chk("store_req_cycles", c_req - s_req, 4);
    chk("store_stall_cycles", c_pelow - s_pe, 5);
    chk("store_wbv_pulses", c_wbv - s_wbv, 0);
    chk1("store_we", req_we, 1'b1);

    snap();
    do_op(1, 1, 0, 32'h0000_0013, '0, 0, '0, -1);
    idle(2);
    chk("misal_req_cycles", c_req - s_req, 0);
    chk("misal_stall_cycles", c_pelow - s_pe, 0);
    chk("misal_align_pulses", c_align - s_align, 1);
    chk("misal_wbv_pulses", c_wbv - s_wbv, 1);
    chk("misal_rdata", wb_last, 32'h0);

    snap();
    do_op(1, 1, 0, 32'h0000_0040, '0, 0, 32'hA5A5_0001, -1);
    do_op(1, 1, 0, 32'h0000_0044, '0, 0, 32'h5A5A_0002, -1);
    idle(2);
    chk("b2b_req_cycles", c_req - s_req, 2);
    chk("b2b_wbv_pulses", c_wbv - s_wbv, 2);
    chk("b2b_first_data", wb_prev, 32'hA5A5_0001);
    chk("b2b_second_data", wb_last, 32'h5A5A_0002);

    snap();
    do_op(1, 1, 0, 32'h0000_0100, '0, 1000, '0, -1);
    idle(2);
    chk("tmo_req_cycles", c_req - s_req, 16);
    chk("tmo_stall_cycles", c_pelow - s_pe, 17);
    chk("tmo_err_pulses", c_terr - s_terr, 1);
    chk("tmo_wbv_pulses", c_wbv - s_wbv, 1);
    chk("tmo_rdata", wb_last, 32'h0);

    snap();
    do_op(1, 0, 1, 32'h0000_0080, 32'hCAFE_F00D, 1000, '0, 1);
    idle(2);
    chk("rst_req_cycles", c_req - s_req, 2);
    chk("rst_align_pulses", c_align - s_align, 0);
    chk("rst_tmo_pulses", c_terr - s_terr, 0);
    chk("rst_wbv_pulses", c_wbv - s_wbv, 0);

    for (int k = 0; k < 80; k++) begin
      rv  = ($urandom_range(0, 9) < 8);
      rr  = 1'($urandom_range(0, 1));
      rwr = 1'($urandom_range(0, 1));
      ra  = $urandom;
      if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
      rw  = $urandom;
      pick = $urandom_range(0, 9);
      if (pick < 6) rl = pick;
      else if (pick == 6) rl = TO - 1;
      else rl = TO + $urandom_range(0, 3);
      do_op(rv, rr, rwr, ra, rw, rl, $urandom, -1);
    end
    idle(2);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs (MemRead, MemWrite, ALU result address, B store data).
- Runs each load/store against a variable-latency data-memory port with a req/ready handshake.
- Drives the shared pipeline `enable` low while an access is outstanding, which stalls EX/MEM and the earlier pipe registers.
- Delivers load data to the MEM/WB register and reports misaligned and timed-out accesses.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT, 16, maximum number of ACCESS cycles spent waiting for mem_ready before the access is aborted (≥2).
- CNT_W, $clog2(TIMEOUT+1), width of the wait counter.

Ports:
- clock  in  1  system clock; every register updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX/MEM holds a real instruction; 0 means bubble.
- ex_mem_read  in  1  MemRead from EX/MEM.
- ex_mem_write  in  1  MemWrite from EX/MEM.
- ex_addr  in  DATA_W  ALU result from EX/MEM; this is the byte address.
- ex_wdata  in  DATA_W  B operand from EX/MEM; this is the store data.
- pipe_enable  out  1  enable for EX/MEM and the upstream pipe registers; 0 means stall.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  DATA_W  word-aligned address.
- mem_wdata  out  DATA_W  store data.
- mem_ready  in  1  memory completion; sampled only in ACCESS.
- mem_rdata  in  DATA_W  load data; valid when mem_ready=1.
- wb_rdata  out  DATA_W  load result to MEM/WB.
- wb_valid  out  1  one-cycle pulse: wb_rdata is valid for a load.
- align_err  out  1  one-cycle pulse: misaligned access was suppressed.
- timeout_err  out  1  one-cycle pulse: access was aborted by timeout.

Behaviour:
- mem_op = ex_valid & (ex_mem_read | ex_mem_write). If both read and write are set, the operation is treated as a store.
- States are IDLE, ACCESS and DONE.
- Reset:
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - wb_rdata=0, wb_valid=0, align_err=0, timeout_err=0, wait counter=0.
  - pipe_enable evaluates to 1 (IDLE with no op).
  - Reset asserted mid-ACCESS drops mem_req on the next edge, and no error pulse is issued.
- pipe_enable (combinational) = (IDLE & ~mem_op) | (IDLE & mem_op & misaligned) | DONE.
- IDLE, mem_op, ex_addr[1:0]==0:
  - Register mem_req=1, mem_we, mem_addr={ex_addr[DATA_W-1:2],2'b00} and mem_wdata.
  - Clear the counter and go to ACCESS.
- IDLE, mem_op, ex_addr[1:0]!=0:
  - No request is issued.
  - Pulse align_err next cycle; the pulse is registered.
  - If it was a load, pulse wb_valid next cycle with wb_rdata=0.
  - Stay in IDLE. The instruction retires this cycle via pipe_enable=1.
- IDLE, no mem_op: no activity, mem_req=0.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - If mem_ready=1: capture mem_rdata into wb_rdata (loads only), drop mem_req and go to DONE.
  - Else if counter==TIMEOUT-1: drop mem_req, pulse timeout_err, set wb_rdata=0 and go to DONE.
  - Else: counter+1.
- DONE:
  - pipe_enable=1 for exactly one cycle, so EX/MEM advances at this edge.
  - wb_valid=1 in this cycle if the op was a load.
  - Unconditionally go to IDLE. A new op is not evaluated in DONE, because EX/MEM still shows the old instruction.
- Latency: with mem_ready in the first ACCESS cycle, a memory op occupies 3 cycles (IDLE, ACCESS, DONE) and pipe_enable is low for 2 cycles. Each extra wait cycle adds one.
- mem_ready outside ACCESS is ignored.
- wb_valid, align_err and timeout_err are never high for more than one cycle.
- wb_rdata holds its last value otherwise.
- Back-to-back memory ops: DONE → IDLE → ACCESS, giving one IDLE cycle between requests.

Decomposition:
- Shared package (mips_pipe_pkg):
  - state encoding localparams ST_IDLE, ST_ACCESS, ST_DONE;
  - WORD_ALIGN_MASK;
  - DATA_W default.
- One sub-module: mem_wait_timer, a clear/increment counter that flags a value of TIMEOUT-1.

Test Plan:
- Load, addr=0x0000_0010, mem_ready on the 1st ACCESS cycle, mem_rdata=0xDEAD_BEEF → mem_req high 1 cycle with mem_we=0 and mem_addr=0x10; pipe_enable low 2 cycles; wb_valid pulse with wb_rdata=0xDEADBEEF.
- Store, addr=0x20, wdata=0x1234_5678, mem_ready after 3 wait cycles → mem_we=1 and address/data stable for 4 ACCESS cycles; pipe_enable low 5 cycles; no wb_valid.
- Load at addr=0x0000_0013 → no mem_req; align_err 1-cycle pulse; wb_valid with wb_rdata=0; pipe_enable stays 1.
- Load, mem_ready never asserted, TIMEOUT=16 → mem_req high exactly 16 cycles; timeout_err pulse; wb_rdata=0; pipeline resumes after DONE.
- Reset asserted on the 2nd ACCESS cycle of a store → mem_req=0 and state IDLE next cycle; all outputs zero; no error pulses.
- Two back-to-back loads (0x40, 0x44), each with zero-wait ready → two requests separated by DONE and IDLE cycles; two wb_valid pulses carrying the correct data in order.
